run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270000, button stable-time in clk cycles (10 ms at 27 MHz); SHALL be >= 2.
REQ-002 Parameter RESET_HOLD, default 4, cycles cpu_rst is held after reset; SHALL be >= 1.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 button  in  1  raw pushbutton level, asynchronous, active-low (0 = pressed).
REQ-006 run_mode  in  1  1 = press starts free-run, 0 = press single-steps.
REQ-007 pc  in  8  current CPU program counter.
REQ-008 bp_en  in  1  breakpoint enable.
REQ-009 bp_addr  in  8  breakpoint PC.
REQ-010 cpu_rst  out  1  synchronous-style reset to CPU datapath, active-high.
REQ-011 cpu_en  out  1  clock enable for PC, gt flag and register/memory writes.
REQ-012 state  out  2  current FSM state encoding.
REQ-013 at_break  out  1  halted by breakpoint.
REQ-014 cycle_count  out  16  number of enabled CPU cycles since reset.

Function
REQ-015 button SHALL pass a 2-flop synchronizer before any other use.
REQ-016 Debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-017 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; release generates no event.
REQ-018 States: RST_HOLD=0, HALT=1, RUN=2, STEP=3.
REQ-019 RST_HOLD: cpu_rst=1, cpu_en=0 for exactly RESET_HOLD cycles, then HALT; press events ignored.
REQ-020 HALT: cpu_en=0; press with run_mode=1 -> RUN; press with run_mode=0 -> STEP; press clears at_break.
REQ-021 STEP: cpu_en=1 for exactly one cycle, then HALT unconditionally; breakpoint ignored.
REQ-022 RUN: cpu_en=1 every cycle unless a breakpoint hit (bp_en=1 and pc==bp_addr), in which case cpu_en=0 combinationally in that cycle, next state HALT, at_break set.
REQ-023 The first RUN cycle after HALT SHALL ignore the breakpoint so resume from a breakpoint PC advances.
REQ-024 RUN: press -> HALT after the current cycle (cpu_en stays 1 that cycle); at_break unchanged.
REQ-025 Press and breakpoint hit in the same RUN cycle: breakpoint wins (cpu_en=0, at_break=1, HALT).
REQ-026 run_mode changes take effect only at the next press from HALT.
REQ-027 cycle_count SHALL increment by 1 in each cycle with cpu_en=1, saturate at 0xFFFF, clear only in RST_HOLD.
REQ-028 cpu_rst and cpu_en SHALL never both be 1.

Reset
REQ-029 rst=1 SHALL immediately force state=RST_HOLD, cpu_rst=1, cpu_en=0, at_break=0, cycle_count=0, hold counter=0, debounce counter=0, synchronizer and debounced level=1 (released).
REQ-030 rst asserted mid-RUN/STEP SHALL abort with no further cpu_en pulse; RST_HOLD timing restarts from rst deassertion.

Structure
REQ-031 State encodings and widths (STATE_W=2, CNT_W=16) SHALL live in shared package run_ctrl_pkg.
REQ-032 Synchronizer+debouncer SHALL be sub-module button_debouncer (params DEBOUNCE_CYCLES; ports clk, rst, button, pressed_pulse).
REQ-033 Counter widths SHALL derive from parameters via $clog2; no other sub-modules.

Verification (DEBOUNCE_CYCLES=4, RESET_HOLD=4)
REQ-034 Release rst -> cpu_rst=1 for exactly 4 cycles, then state=1, cpu_en=0, cycle_count=0.
REQ-035 run_mode=0, button low for 10 cycles with 2-cycle glitches before it -> exactly one cpu_en pulse, cycle_count=1, state back to 1.
REQ-036 run_mode=1, press, bp_en=1, bp_addr=0x05, pc driven 0..5 following cpu_en -> cpu_en=0 at pc=0x05, at_break=1, state=1, cycle_count=5.
REQ-037 From REQ-036 end, press again -> first RUN cycle cpu_en=1 at pc=0x05, at_break=0, run continues past 0x05.
REQ-038 In RUN, press and breakpoint hit same cycle -> cpu_en=0, at_break=1, HALT; force 0xFFFF enables -> cycle_count stays 0xFFFF.
REQ-039 Assert rst during RUN -> cpu_en=0 and cpu_rst=1 same cycle, state=0, cycle_count=0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared encodings and widths for the CPU run controller.
package run_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 16;

    localparam logic [STATE_W-1:0] ST_RST_HOLD = 2'd0;
    localparam logic [STATE_W-1:0] ST_HALT     = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN      = 2'd2;
    localparam logic [STATE_W-1:0] ST_STEP     = 2'd3;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer and stable-time debouncer for an active-low pushbutton;
// emits a one-cycle pulse when the debounced level falls (press).
module button_debouncer
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            level         <= 1'b1;
            db_cnt        <= '0;
            pressed_pulse <= 1'b0;
        end else begin
            sync1         <= button;
            sync2         <= sync1;
            pressed_pulse <= 1'b0;
            // Any cycle where the synchronized input matches the level restarts the count.
            if (sync2 != level) begin
                if (db_cnt == DB_LAST) begin
                    level         <= sync2;
                    db_cnt        <= '0;
                    pressed_pulse <= ~sync2;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run/step/breakpoint controller: gates the CPU clock enable from a debounced
// pushbutton and holds the CPU in reset for a fixed number of cycles.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int RESET_HOLD      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic               run_mode,
    input  logic [7:0]         pc,
    input  logic               bp_en,
    input  logic [7:0]         bp_addr,
    output logic               cpu_rst,
    output logic               cpu_en,
    output logic [STATE_W-1:0] state,
    output logic               at_break,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    logic               press;
    logic               bp_hit;
    logic               first_run;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STATE_W-1:0] state_next;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .rst          (rst),
        .button       (button),
        .pressed_pulse(press)
    );

    // The first RUN cycle ignores the breakpoint so a resume from the break PC advances.
    always_comb begin
        bp_hit  = (state == ST_RUN) && !first_run && bp_en && (pc == bp_addr);
        cpu_en  = (state == ST_STEP) || ((state == ST_RUN) && !bp_hit);
        cpu_rst = (state == ST_RST_HOLD);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST_HOLD: if (hold_cnt == HOLD_LAST) state_next = ST_HALT;
            ST_HALT:     if (press) state_next = run_mode ? ST_RUN : ST_STEP;
            ST_RUN:      if (bp_hit || press) state_next = ST_HALT;
            ST_STEP:     state_next = ST_HALT;
            default:     state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RST_HOLD;
            hold_cnt    <= '0;
            at_break    <= 1'b0;
            first_run   <= 1'b0;
            cycle_count <= '0;
        end else begin
            state     <= state_next;
            hold_cnt  <= ((state == ST_RST_HOLD) && (hold_cnt != HOLD_LAST)) ? hold_cnt + 1'b1 : '0;
            first_run <= (state == ST_HALT) && press && run_mode;

            if (state == ST_RST_HOLD) begin
                cycle_count <= '0;
            end else if (cpu_en) begin
                cycle_count <= sat_inc(cycle_count);
            end

            if ((state == ST_HALT) && press) begin
                at_break <= 1'b0;
            end else if (bp_hit) begin
                at_break <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed table, hand sequences and randomized
// stimulus checked against a history-based behavioural model.
module tb_run_controller;

    localparam int DB = 4;
    localparam int RH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        button;
    logic        run_mode;
    logic [7:0]  pc;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic        cpu_rst;
    logic        cpu_en;
    logic [1:0]  state;
    logic        at_break;
    logic [15:0] cycle_count;

    run_controller #(
        .DEBOUNCE_CYCLES(DB),
        .RESET_HOLD     (RH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .run_mode   (run_mode),
        .pc         (pc),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .cpu_rst    (cpu_rst),
        .cpu_en     (cpu_en),
        .state      (state),
        .at_break   (at_break),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: modes 0=reset hold, 1=halt, 2=run, 3=step.
    int m_mode, m_hold, m_count;
    bit m_brk, m_first, m_deb, m_press;
    bit m_raw[$];
    bit m_s2h[$];
    bit follow_pc;
    int pc_reg;

    task automatic model_reset();
        m_mode = 0; m_hold = 0; m_count = 0;
        m_brk = 0; m_first = 0; m_deb = 1; m_press = 0;
        m_raw.delete();
        m_s2h.delete();
    endtask

    function automatic bit m_s2();
        return (m_raw.size() >= 2) ? m_raw[m_raw.size()-2] : 1'b1;
    endfunction

    function automatic bit m_hit();
        return (m_mode == 2) && !m_first && bp_en && (pc == bp_addr);
    endfunction

    function automatic bit m_en();
        return (m_mode == 3) || ((m_mode == 2) && !m_hit());
    endfunction

    task automatic model_edge();
        bit en, hit, s2, prs, all_diff;
        en = m_en(); hit = m_hit(); s2 = m_s2(); prs = m_press;
        if (m_mode == 0) m_count = 0;
        else if (en && m_count < 65535) m_count++;
        case (m_mode)
            0: begin m_hold++; if (m_hold == RH) m_mode = 1; end
            1: if (prs) begin m_brk = 0; m_first = run_mode; m_mode = run_mode ? 2 : 3; end
            2: begin
                m_first = 0;
                if (hit) begin m_mode = 1; m_brk = 1; end
                else if (prs) m_mode = 1;
            end
            default: m_mode = 1;
        endcase
        // Debounced level flips once the last DB synchronized samples all disagree with it.
        m_s2h.push_back(s2);
        if (m_s2h.size() > DB) void'(m_s2h.pop_front());
        m_press = 0;
        if (m_s2h.size() == DB) begin
            all_diff = 1;
            foreach (m_s2h[i]) if (m_s2h[i] == m_deb) all_diff = 0;
            if (all_diff) begin
                m_deb = !m_deb;
                m_press = (m_deb == 0);
            end
        end
        m_raw.push_back(button);
        if (m_raw.size() > 2) void'(m_raw.pop_front());
    endtask

    task automatic check_model();
        if (rst) model_reset();
        chk("cpu_rst",     int'(cpu_rst),     int'(m_mode == 0));
        chk("cpu_en",      int'(cpu_en),      int'(m_en()));
        chk("state",       int'(state),       m_mode);
        chk("at_break",    int'(at_break),    int'(m_brk));
        chk("cycle_count", int'(cycle_count), m_count);
        chk("never_rst_and_en", int'(cpu_rst && cpu_en), 0);
    endtask

    task automatic advance();
        bit en_pre;
        en_pre = m_en();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge();
            if (follow_pc && en_pre) pc_reg = (pc_reg + 1) % 256;
        end
        @(negedge clk);
        if (follow_pc) pc = 8'(pc_reg);
    endtask

    task automatic step();
        #1;
        check_model();
        advance();
    endtask

    task automatic wait_state(input int s, input int limit, input string name);
        for (int i = 0; i < limit && state != 2'(s); i++) step();
        chk(name, int'(state), s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    typedef struct {
        bit btn;
        int st;
        bit crst;
        bit en;
        int cnt;
    } vec_t;
    vec_t tbl[20];

    initial begin
        int pulses;

        rst = 1'b1; button = 1'b1; run_mode = 1'b0; bp_en = 1'b0;
        bp_addr = 8'h00; pc = 8'h00; follow_pc = 0; pc_reg = 0;
        model_reset();

        for (int i = 0; i < 20; i++) begin
            tbl[i].btn  = (i >= 4 && i <= 11) ? 1'b0 : 1'b1;
            tbl[i].st   = (i < 4) ? 0 : (i == 11) ? 3 : 1;
            tbl[i].crst = (i < 4);
            tbl[i].en   = (i == 11);
            tbl[i].cnt  = (i >= 12) ? 1 : 0;
        end

        @(negedge clk);
        step();
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_cpu_rst", int'(cpu_rst), 1);
        chk("reset_count", int'(cycle_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset hold timing, single step, release without event.
        for (int i = 0; i < 20; i++) begin
            button = tbl[i].btn;
            #1;
            chk($sformatf("tbl%0d_state", i),   int'(state),       tbl[i].st);
            chk($sformatf("tbl%0d_cpu_rst", i), int'(cpu_rst),     int'(tbl[i].crst));
            chk($sformatf("tbl%0d_cpu_en", i),  int'(cpu_en),      int'(tbl[i].en));
            chk($sformatf("tbl%0d_count", i),   int'(cycle_count), tbl[i].cnt);
            check_model();
            advance();
        end

        // Glitches shorter than the debounce time, then one real press.
        pulses = 0;
        for (int g = 0; g < 2; g++) begin
            button = 1'b0; step(); step();
            button = 1'b1; step(); step(); step();
        end
        button = 1'b0;
        for (int i = 0; i < 10; i++) begin #1; pulses += int'(cpu_en); check_model(); advance(); end
        button = 1'b1;
        for (int i = 0; i < 10; i++) begin #1; pulses += int'(cpu_en); check_model(); advance(); end
        chk("glitch_single_pulse", pulses, 1);
        chk("glitch_count", int'(cycle_count), 2);
        chk("glitch_state", int'(state), 1);

        // Free run to a breakpoint with pc following cpu_en.
        do_reset();
        wait_state(1, 20, "bp_reach_halt");
        follow_pc = 1; pc_reg = 0; pc = 8'h00;
        run_mode = 1'b1; bp_en = 1'b1; bp_addr = 8'h05;
        button = 1'b0;
        wait_state(2, 20, "bp_enter_run");
        button = 1'b1;
        for (int i = 0; i < 20 && pc != 8'h05; i++) step();
        #1;
        chk("bp_pc_reached", int'(pc), 5);
        chk("bp_hit_cpu_en", int'(cpu_en), 0);
        check_model();
        advance();
        chk("bp_state", int'(state), 1);
        chk("bp_at_break", int'(at_break), 1);
        chk("bp_count", int'(cycle_count), 5);
        for (int i = 0; i < 8; i++) step();

        // Resume from the breakpoint PC.
        button = 1'b0;
        wait_state(2, 20, "resume_run");
        #1;
        chk("resume_cpu_en", int'(cpu_en), 1);
        chk("resume_at_break", int'(at_break), 0);
        check_model();
        advance();
        button = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("resume_past_bp", int'(pc_reg > 5), 1);
        for (int i = 0; i < 8; i++) step();

        // Press and breakpoint in the same RUN cycle.
        follow_pc = 0; pc = 8'h10; bp_addr = 8'hAA;
        button = 1'b0;
        for (int i = 0; i < 20 && !(m_press && m_mode == 2); i++) step();
        chk("tie_press_seen", int'(m_press && m_mode == 2), 1);
        pc = 8'hAA;
        #1;
        chk("tie_cpu_en", int'(cpu_en), 0);
        check_model();
        advance();
        chk("tie_state", int'(state), 1);
        chk("tie_at_break", int'(at_break), 1);
        button = 1'b1; pc = 8'h10;
        for (int i = 0; i < 8; i++) step();

        // Counter saturation.
        bp_en = 1'b0;
        button = 1'b0;
        wait_state(2, 20, "sat_run");
        button = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        chk("sat_count", int'(cycle_count), 65535);
        for (int i = 0; i < 3; i++) step();
        chk("sat_hold", int'(cycle_count), 65535);

        // Asynchronous reset in RUN.
        chk("pre_rst_run", int'(state), 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_cpu_en", int'(cpu_en), 0);
        chk("arst_cpu_rst", int'(cpu_rst), 1);
        chk("arst_state", int'(state), 0);
        chk("arst_count", int'(cycle_count), 0);
        model_reset();
        advance();
        step();
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            button   = 1'($urandom_range(0, 1));
            run_mode = 1'($urandom_range(0, 1));
            bp_en    = 1'($urandom_range(0, 1));
            bp_addr  = 8'($urandom_range(0, 7));
            len      = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                pc  = 8'($urandom_range(0, 7));
                rst = ($urandom_range(0, 99) == 0);
                step();
            end
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
